tcm_arbiter_2p: RTL

Two-port arbiter that shares the single-port 32KB TCM (8k x 32, byte strobes) between the core data port (port A) and the AXI slave/DMA path (port B). It grants one access at a time with fixed priority to A and a starvation guard for B. It sequences the TCM's read timing, holding the address through the read-mux cycle, and returns tagged read data to the owning port.

---
 rtl/tcm_arb_pkg.sv | 11 +
 rtl/tcm_arb_starve_ctr.sv | 25 ++
 rtl/tcm_arbiter_2p.sv | 117 +++++++++++
 3 files changed

// File: rtl/tcm_arb_pkg.sv
// Shared types and constants for the two-port TCM arbiter.
package tcm_arb_pkg;

  localparam int unsigned TCM_ADDR_W = 13;
  localparam int unsigned TCM_DATA_W = 32;

  typedef enum logic {OWN_A, OWN_B} owner_e;

  typedef enum logic {ST_IDLE, ST_RD_HOLD} state_e;

endpackage

// File: rtl/tcm_arb_starve_ctr.sv
// Saturating counter of consecutive cycles port B has waited without a grant.
module tcm_arb_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != W'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat_o = (r_cnt == W'(MAX));

endmodule

// File: rtl/tcm_arbiter_2p.sv
// Shares the single-port TCM between the core data port (A) and the AXI/DMA
// path (B): fixed priority to A, starvation guard for B, 2-cycle read return.
module tcm_arbiter_2p
  import tcm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = TCM_ADDR_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [ADDR_W-1:0]     a_addr_i,
  input  logic [TCM_DATA_W-1:0] a_wdata_i,
  input  logic [3:0]            a_wstrb_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [TCM_DATA_W-1:0] a_rdata_o,
  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [ADDR_W-1:0]     b_addr_i,
  input  logic [TCM_DATA_W-1:0] b_wdata_i,
  input  logic [3:0]            b_wstrb_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [TCM_DATA_W-1:0] b_rdata_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [TCM_DATA_W-1:0] mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  output logic                  mem_we_o,
  input  logic [TCM_DATA_W-1:0] mem_rdata_i
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_p0_v;
  owner_e            r_p0_own;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              w_rd_gnt;
  owner_e            w_rd_own;
  logic              w_starve_sat;

  tcm_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (b_req_i && !b_gnt_o),
    .clr_i (!b_req_i || b_gnt_o),
    .sat_o (w_starve_sat)
  );

  // Grants are suppressed while reset is held so no access escapes to the TCM.
  always_comb begin
    w_state_nxt = r_state;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    mem_addr_o  = r_addr;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    mem_we_o    = 1'b0;
    w_rd_gnt    = 1'b0;
    w_rd_own    = OWN_A;
    case (r_state)
      ST_IDLE: begin
        if (!rst_i) begin
          if (a_req_i && !(b_req_i && w_starve_sat)) begin
            a_gnt_o     = 1'b1;
            mem_addr_o  = a_addr_i;
            mem_wdata_o = a_wdata_i;
            mem_wstrb_o = a_wstrb_i;
            mem_we_o    = a_we_i;
            w_rd_gnt    = !a_we_i;
            w_rd_own    = OWN_A;
          end else if (b_req_i) begin
            b_gnt_o     = 1'b1;
            mem_addr_o  = b_addr_i;
            mem_wdata_o = b_wdata_i;
            mem_wstrb_o = b_wstrb_i;
            mem_we_o    = b_we_i;
            w_rd_gnt    = !b_we_i;
            w_rd_own    = OWN_B;
          end
          if (w_rd_gnt) w_state_nxt = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_p0_v     <= 1'b0;
      r_p0_own   <= OWN_A;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_gnt) r_addr <= mem_addr_o;
      r_p0_v     <= w_rd_gnt;
      r_p0_own   <= w_rd_own;
      r_a_rvalid <= r_p0_v && (r_p0_own == OWN_A);
      r_b_rvalid <= r_p0_v && (r_p0_own == OWN_B);
    end
  end

  assign a_rvalid_o = r_a_rvalid;
  assign b_rvalid_o = r_b_rvalid;
  assign a_rdata_o  = mem_rdata_i;
  assign b_rdata_o  = mem_rdata_i;

endmodule
